// File: rtl/nn_classification_scheduler.sv
// Batch sequencer for forward_nn_classification_bram: header parse, weight/input BRAM loads, core start/done, result streaming.
// Optional weight cache (reuse weights across packets): define NN_SCHED_WGT_CACHE_EN.
module nn_classification_scheduler #(
    parameter int WGT_WORDS = 10,
    parameter int INP_WORDS = 9,
    parameter int OUT_WORDS = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        wb_ena,
    output logic [7:0]  wb_wea,
    output logic [3:0]  wb_addra,
    output logic [63:0] wb_dina,
    output logic        xij_ena,
    output logic [7:0]  xij_wea,
    output logic [3:0]  xij_addra,
    output logic [63:0] xij_dina,
    output logic        core_start,
    input  logic        core_done,
    output logic        xout_enb,
    output logic [3:0]  xout_addrb,
    input  logic [15:0] xout_doutb,
    output logic        busy,
    output logic        err_no_wgt,
    output logic [7:0]  sample_idx
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_WGT, S_INP, S_START, S_ARM, S_WAIT, S_RD_ISSUE, S_RD_CAP, S_RD_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  word_cnt_q;
    logic [3:0]  out_cnt_q;
    logic [7:0]  sample_q;
    logic [7:0]  n_q;
    logic        drop_q;
    logic        tready_q;
    logic        start_q;
    logic        busy_q;
    logic        enb_q;
    logic [63:0] mdata_q;
    logic        mvalid_q;
    logic        mlast_q;

    logic        s_hs;
    logic        wgt_last;
    logic        inp_last;
    logic        out_last;
    logic        last_sample;
    logic        hdr_need_wgt;
    logic        hdr_drop;
    logic [7:0]  hdr_n;

    assign s_hs        = s_axis_tvalid & tready_q;
    assign hdr_n       = s_axis_tdata[15:8];
    assign wgt_last    = (word_cnt_q == 4'(WGT_WORDS - 1));
    assign inp_last    = (word_cnt_q == 4'(INP_WORDS - 1));
    assign out_last    = (out_cnt_q == 4'(OUT_WORDS - 1));
    assign last_sample = (sample_q == n_q - 8'd1);

`ifdef NN_SCHED_WGT_CACHE_EN
    logic wgt_valid_q;
    logic err_q;

    // Without loaded weights a no-weight header cannot run; its inputs are drained instead.
    assign hdr_need_wgt = s_axis_tdata[0];
    assign hdr_drop     = ~s_axis_tdata[0] & ~wgt_valid_q;
    assign err_no_wgt   = err_q;
`else
    assign hdr_need_wgt = 1'b1;
    assign hdr_drop     = 1'b0;
    assign err_no_wgt   = 1'b0;
`endif

    assign s_axis_tready = tready_q;
    assign wb_ena        = (state_q == S_WGT) & s_hs;
    assign wb_wea        = {8{wb_ena}};
    assign wb_addra      = word_cnt_q;
    assign wb_dina       = s_axis_tdata;
    assign xij_ena       = (state_q == S_INP) & s_hs & ~drop_q;
    assign xij_wea       = {8{xij_ena}};
    assign xij_addra     = word_cnt_q;
    assign xij_dina      = s_axis_tdata;
    assign core_start    = start_q;
    assign xout_enb      = enb_q;
    assign xout_addrb    = out_cnt_q;
    assign m_axis_tdata  = mdata_q;
    assign m_axis_tvalid = mvalid_q;
    assign m_axis_tlast  = mlast_q;
    assign busy          = busy_q;
    assign sample_idx    = sample_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_HDR;
            S_HDR: begin
                if (s_hs) begin
                    if (hdr_need_wgt)       state_d = S_WGT;
                    else if (hdr_n == 8'd0) state_d = S_IDLE;
                    else                    state_d = S_INP;
                end
            end
            S_WGT: begin
                if (s_hs && wgt_last) state_d = (n_q == 8'd0) ? S_IDLE : S_INP;
            end
            S_INP: begin
                if (s_hs && inp_last) begin
                    if (!drop_q)          state_d = S_START;
                    else if (last_sample) state_d = S_IDLE;
                end
            end
            S_START:    state_d = S_ARM;
            // ARM skips one cycle so a done level left over from the previous run is ignored.
            S_ARM:      state_d = S_WAIT;
            S_WAIT:     if (core_done) state_d = S_RD_ISSUE;
            S_RD_ISSUE: state_d = S_RD_CAP;
            S_RD_CAP:   state_d = S_RD_HOLD;
            S_RD_HOLD: begin
                if (m_axis_tready) begin
                    if (!out_last)        state_d = S_RD_ISSUE;
                    else if (last_sample) state_d = S_IDLE;
                    else                  state_d = S_INP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            out_cnt_q  <= '0;
            sample_q   <= '0;
            n_q        <= '0;
            drop_q     <= 1'b0;
            tready_q   <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            enb_q      <= 1'b0;
            mdata_q    <= '0;
            mvalid_q   <= 1'b0;
            mlast_q    <= 1'b0;
`ifdef NN_SCHED_WGT_CACHE_EN
            wgt_valid_q <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tready_q <= (state_d == S_HDR) || (state_d == S_WGT) || (state_d == S_INP);
            start_q  <= (state_d == S_START);
            busy_q   <= (state_d != S_IDLE);
            enb_q    <= (state_d == S_RD_ISSUE);

            // A dropped sample stays in INP, so its word count wraps explicitly.
            if ((state_d != state_q) || ((state_q == S_INP) && s_hs && inp_last))
                word_cnt_q <= '0;
            else if (s_hs)
                word_cnt_q <= word_cnt_q + 4'd1;

            case (state_q)
                S_HDR: begin
                    if (s_hs) begin
                        n_q       <= hdr_n;
                        drop_q    <= hdr_drop;
                        sample_q  <= '0;
                        out_cnt_q <= '0;
`ifdef NN_SCHED_WGT_CACHE_EN
                        err_q <= hdr_drop;
                        if (hdr_need_wgt) wgt_valid_q <= 1'b0;
`endif
                    end
                end
                S_WGT: begin
`ifdef NN_SCHED_WGT_CACHE_EN
                    if (s_hs && wgt_last) wgt_valid_q <= 1'b1;
`endif
                end
                S_INP: begin
                    if (s_hs && inp_last && drop_q)
                        sample_q <= last_sample ? 8'd0 : sample_q + 8'd1;
                end
                S_RD_CAP: begin
                    mdata_q  <= {xout_doutb, 48'd0};
                    mvalid_q <= 1'b1;
                    mlast_q  <= out_last & last_sample;
                end
                S_RD_HOLD: begin
                    if (m_axis_tready) begin
                        mvalid_q <= 1'b0;
                        mlast_q  <= 1'b0;
                        if (out_last) begin
                            out_cnt_q <= '0;
                            sample_q  <= last_sample ? 8'd0 : sample_q + 8'd1;
                        end else begin
                            out_cnt_q <= out_cnt_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/nn_classification_scheduler.md
# nn_classification_scheduler

Sequencing controller for the `forward_nn_classification_bram` core. It parses a headered 64-bit AXI-Stream command packet and loads the weight/bias BRAM when the header requests it. For each sample in the batch, it loads the input BRAM, starts the core, waits for `done`, and streams the 4 output words to an AXI-Stream master. It replaces the fixed single-sample sequencer between the MM2S and S2MM FIFOs and lets one weight load serve a batch of up to 255 samples.

## Interface
Parameters:
- `WGT_WORDS`, 10: weight/bias words per load.
- `INP_WORDS`, 9: input words per sample.
- `OUT_WORDS`, 4: output words per sample.

Ports:
- `aclk`  in  1  clock.
- `areset`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  64  command/weight/input words.
- `s_axis_tvalid`  in  1  upstream valid.
- `s_axis_tready`  out  1  scheduler accepts word.
- `m_axis_tdata`  out  64  result word `{xout_doutb, 48'd0}`.
- `m_axis_tvalid`  out  1  result valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last word of the batch.
- `wb_ena`, `wb_wea[7:0]`, `wb_addra[3:0]`, `wb_dina[63:0]`  out  core weight BRAM write port.
- `xij_ena`, `xij_wea[7:0]`, `xij_addra[3:0]`, `xij_dina[63:0]`  out  core input BRAM write port.
- `core_start`  out  1  one-cycle start pulse.
- `core_done`  in  1  core done level.
- `xout_enb`, `xout_addrb[3:0]`  out  core output BRAM read port.
- `xout_doutb`  in  16  read data, 1-cycle latency.
- `busy`  out  1  high in every state except IDLE.
- `err_no_wgt`  out  1  sticky error, cleared on the next header.
- `sample_idx`  out  8  index of the sample in progress.

## Operation
- Header word fields:
  - bit0 is `wgt_flag`: 10 weight words follow the header.
  - bits[15:8] are `N`, the sample count.
  - Other bits are ignored.
- States and transitions:
  - IDLE → HDR.
  - HDR: on header handshake, latch `N` and `wgt_flag`.
  - HDR → WGT if weights are required, else → INP.
  - WGT → INP after `WGT_WORDS` words.
  - INP → START after `INP_WORDS` words.
  - START → ARM → WAIT.
  - WAIT → RD_ISSUE when `core_done` is high.
  - RD_ISSUE → RD_CAP → RD_HOLD.
  - RD_HOLD: when the result is accepted, return to RD_ISSUE for the next word. After `OUT_WORDS` words, go to INP for the next sample, or to IDLE after the last sample.
- `s_axis_tready` is high only in HDR, WGT and INP.
- A BRAM write occurs exactly on the handshake cycle:
  - `*_ena` = `valid & ready` within that state.
  - `*_wea` = 8'hFF on that cycle.
  - `*_addra` = word counter.
  - `*_dina` = `s_axis_tdata`.
- The word counter increments per handshake and clears on every state change.
- `core_start` is high only in START. ARM is a one-cycle guard so a stale `done` from the previous run is never sampled.
- Output read:
  - RD_ISSUE drives `xout_enb`=1 with `xout_addrb` = output counter.
  - RD_CAP registers `xout_doutb` into the output register and sets `m_axis_tvalid`.
  - RD_HOLD holds data and valid stable until `m_axis_tready`.
- `m_axis_tlast` = 1 only on output word `OUT_WORDS-1` of sample `N-1`.
- `N`=0: the header is consumed and weights load if requested. No samples run and no output is produced; the block returns to IDLE.
- `sample_idx` counts 0..N-1 and wraps to 0 at batch end.

## Timing
- Reset values:
  - State = IDLE; all counters = 0.
  - `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast`, `core_start`, all enables/write enables, `busy` and `err_no_wgt` = 0.
  - Output data = 0; weight-valid flag = 0.
- Reset asserted mid-operation aborts at once. The core's own reset is external, so the core is not reset by this block. Partial BRAM contents are not trusted: the weight-valid flag clears.
- Input: one word per cycle at full rate. Header-to-first-BRAM-write latency is 1 cycle.
- Start: `core_start` fires 1 cycle after the last input handshake.
- Done: `core_done` is first sampled 2 cycles after `core_start`.
- Output: 3 cycles per result word with `m_axis_tready` held high. Back-pressure stretches RD_HOLD indefinitely with data unchanged.
- `m_axis_tvalid` never drops without a handshake.

## Configuration
- `NN_SCHED_WGT_CACHE_EN` defined:
  - The weight-valid flag sets after a complete WGT phase.
  - A header with `wgt_flag`=0 skips WGT and reuses the loaded weights.
  - A header with `wgt_flag`=0 while the flag is 0 sets `err_no_wgt`. All N×9 input words are then consumed and dropped: no start, no output.
- Undefined:
  - `wgt_flag` is ignored and WGT always runs for every packet.
  - `err_no_wgt` is tied to 0.

## Test plan
- Header `N`=1, `wgt_flag`=1; 10 weight words then 9 input words; `core_done` 20 cycles after start:
  - Expect `wb_addra` writes 0..9 and `xij_addra` writes 0..8.
  - Expect a single `core_start` pulse.
  - Expect 4 outputs `{doutb,48'd0}` with `tlast` only on the 4th.
- Header `N`=3: expect 3 start pulses and 12 outputs; `sample_idx` goes 0,1,2; `tlast` only on the 12th word.
- `m_axis_tready` toggling 1/0 every cycle: data is stable through stalls and exactly 4 words per sample are delivered, none duplicated.
- With cache enabled, header (`wgt_flag`=1, `N`=1) then header (`wgt_flag`=0, `N`=2): the second packet produces no `wb_ena` and 8 outputs.
- With cache enabled and directly after reset, header (`wgt_flag`=0, `N`=1): `err_no_wgt`=1, 9 words consumed, no `core_start`, no output.
- `areset` pulsed while in WAIT: all outputs return to reset values within the same cycle, and a following `N`=1 packet with weights completes normally.
